// File: rtl/multi_ch_ack_sink_pkg.sv
// -----------------------------------------------------------------------------
// hs_pkg
// Shared types and helpers for the multi-channel 4-phase acknowledge sink.
//   ch_state_t : per-channel handshake state (CH_IDLE waiting, CH_ACK acknowledged)
//   ch_idx_w() : width of a channel index, never less than one bit
// -----------------------------------------------------------------------------
package hs_pkg;

    typedef enum logic [0:0] {
        CH_IDLE = 1'b0,
        CH_ACK  = 1'b1
    } ch_state_t;

    // Width needed to hold a channel index; a single channel still gets one bit.
    function automatic int ch_idx_w(input int n);
        if ($clog2(n) < 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage : hs_pkg

// File: rtl/multi_ch_ack_sink_if.sv
// -----------------------------------------------------------------------------
// multi_ch_ack_sink_if
// Bundles the per-channel 4-phase request/acknowledge lines, the channel
// payloads and the downstream valid/ready output slot.
//   async_req  : per-channel request levels from foreign clock domains
//   async_data : per-channel payloads, stable while a request is outstanding
//   ack        : per-channel acknowledge levels back to the sources
//   out_data   : captured payload
//   out_ch     : channel index that produced out_data
//   out_valid  : output slot holds a word
//   out_ready  : downstream accepts when out_valid && out_ready
// Modports: slave = the sink, master = the sources plus downstream consumer.
// -----------------------------------------------------------------------------
interface multi_ch_ack_sink_if
    import hs_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 8,
    localparam int CH_W      = ch_idx_w(NUM_CH)
);

    logic [NUM_CH-1:0]                  async_req;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0]  async_data;
    logic [NUM_CH-1:0]                  ack;
    logic [DATA_WIDTH-1:0]              out_data;
    logic [CH_W-1:0]                    out_ch;
    logic                               out_valid;
    logic                               out_ready;

    modport slave (
        input  async_req,
        input  async_data,
        input  out_ready,
        output ack,
        output out_data,
        output out_ch,
        output out_valid
    );

    modport master (
        output async_req,
        output async_data,
        output out_ready,
        input  ack,
        input  out_data,
        input  out_ch,
        input  out_valid
    );

endinterface : multi_ch_ack_sink_if

// File: rtl/multi_ch_ack_sink_rr_arb.sv
// -----------------------------------------------------------------------------
// rr_arb
// Round-robin arbiter. The search starts at the channel after the last one
// granted and wraps from NUM_CH-1 to 0. After reset the pointer sits on
// NUM_CH-1 so channel 0 has top priority.
//   clk, rst : clock and asynchronous active-high reset
//   i_req    : request vector (already qualified by the caller)
//   o_grant  : one-hot grant, all zero when nothing requests
//   o_idx    : index of the granted channel
//   o_any    : a grant is being issued this cycle
// -----------------------------------------------------------------------------
module rr_arb
    import hs_pkg::*;
#(
    parameter int NUM_CH = 4,
    localparam int CH_W  = ch_idx_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] i_req,
    output logic [NUM_CH-1:0] o_grant,
    output logic [CH_W-1:0]   o_idx,
    output logic              o_any
);

    logic [CH_W-1:0]   r_last;
    logic [NUM_CH-1:0] w_grant;
    logic [CH_W-1:0]   w_idx;
    logic [CH_W-1:0]   w_pos;
    logic              w_any;
    logic              w_hit;

    // First requester at or after r_last+1 (modulo NUM_CH) wins.
    always_comb begin
        w_grant = '0;
        w_idx   = '0;
        w_pos   = '0;
        w_any   = 1'b0;
        w_hit   = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_pos          = CH_W'((int'(r_last) + 1 + k) % NUM_CH);
            w_hit          = ~w_any & i_req[w_pos];
            w_grant[w_pos] = w_grant[w_pos] | w_hit;
            w_idx          = w_hit ? w_pos : w_idx;
            w_any          = w_any | w_hit;
        end
    end

    // Pointer remembers the most recent grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= CH_W'(NUM_CH - 1);
        end else if (w_any) begin
            r_last <= w_idx;
        end else begin
            r_last <= r_last;
        end
    end

    assign o_grant = w_grant;
    assign o_idx   = w_idx;
    assign o_any   = w_any;

endmodule : rr_arb

// File: rtl/multi_ch_ack_sink.sv
// -----------------------------------------------------------------------------
// multi_ch_ack_sink
// Collects words from NUM_CH independent 4-phase request/acknowledge sources
// living in foreign clock domains and funnels them into one valid/ready slot.
// Each request is synchronized through SYNC_STAGES flops; a pending channel
// is granted round-robin when the output slot is free, its payload is loaded
// into the slot and its acknowledge rises on the same edge. The acknowledge
// stays high until the synchronized request is seen low, so a request held
// high is captured once.
//   clk : sole clock
//   rst : asynchronous active-high reset
//   bus : multi_ch_ack_sink_if.slave (requests, payloads, acks, output slot)
// -----------------------------------------------------------------------------
module multi_ch_ack_sink
    import hs_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    localparam int CH_W       = ch_idx_w(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    multi_ch_ack_sink_if.slave    bus
);

    logic [NUM_CH-1:0]     r_sync [SYNC_STAGES];
    ch_state_t             r_state [NUM_CH];
    logic [DATA_WIDTH-1:0] r_data;
    logic [CH_W-1:0]       r_ch;
    logic                  r_valid;

    ch_state_t             w_state_nxt [NUM_CH];
    logic [NUM_CH-1:0]     w_req_s;
    logic [NUM_CH-1:0]     w_pend;
    logic [NUM_CH-1:0]     w_arb_req;
    logic [NUM_CH-1:0]     w_grant;
    logic [NUM_CH-1:0]     w_ack;
    logic [CH_W-1:0]       w_idx;
    logic                  w_any;
    logic                  w_slot_free;

    // Request synchronizer chain, one shift register per channel bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= bus.async_req;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_req_s     = r_sync[SYNC_STAGES-1];
    assign w_slot_free = ~r_valid | bus.out_ready;

    // Pending channels compete only when the slot can take a word this edge.
    always_comb begin
        w_pend    = '0;
        w_arb_req = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_pend[i] = (r_state[i] == CH_IDLE) & w_req_s[i];
        end
        if (w_slot_free) begin
            w_arb_req = w_pend;
        end else begin
            w_arb_req = '0;
        end
    end

    rr_arb #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_req   (w_arb_req),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Per-channel handshake next state; CH_ACK ignores req_s until it drops.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_state_nxt[i] = CH_IDLE;
            case (r_state[i])
                CH_IDLE: w_state_nxt[i] = w_grant[i] ? CH_ACK : CH_IDLE;
                CH_ACK:  w_state_nxt[i] = w_req_s[i] ? CH_ACK : CH_IDLE;
                default: w_state_nxt[i] = CH_IDLE;
            endcase
        end
    end

    // Per-channel handshake state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= CH_IDLE;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= w_state_nxt[i];
            end
        end
    end

    // Acknowledge is a direct decode of the state flop, so it is glitch-free.
    always_comb begin
        w_ack = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_ack[i] = (r_state[i] == CH_ACK);
        end
    end

    // Output slot: load on grant (also back-to-back with an accept),
    // clear on an accept without a grant, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_ch    <= '0;
            r_valid <= 1'b0;
        end else if (w_any) begin
            r_data  <= bus.async_data[w_idx];
            r_ch    <= w_idx;
            r_valid <= 1'b1;
        end else if (bus.out_ready) begin
            r_data  <= r_data;
            r_ch    <= r_ch;
            r_valid <= 1'b0;
        end else begin
            r_data  <= r_data;
            r_ch    <= r_ch;
            r_valid <= r_valid;
        end
    end

    assign bus.ack       = w_ack;
    assign bus.out_data  = r_data;
    assign bus.out_ch    = r_ch;
    assign bus.out_valid = r_valid;

endmodule : multi_ch_ack_sink

// File: tb/tb_multi_ch_ack_sink.sv
// -----------------------------------------------------------------------------
// tb_multi_ch_ack_sink
// Directed, self-checking bench for multi_ch_ack_sink with NUM_CH=4,
// DATA_WIDTH=8, SYNC_STAGES=2. Inputs change 1 time unit after a rising edge
// and outputs are sampled at the same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_multi_ch_ack_sink;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    multi_ch_ack_sink_if #(.NUM_CH(4), .DATA_WIDTH(8)) bus ();

    multi_ch_ack_sink #(
        .NUM_CH      (4),
        .DATA_WIDTH  (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.async_req = 4'b0000;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.async_req  = 4'b0000;
        bus.async_data = '0;
        bus.out_ready  = 1'b1;
        #2;
        checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got=%b want=0000", bus.ack); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h want=00", bus.out_data); end
        checks++; if (bus.out_ch !== 2'd0) begin errors++; $display("FAIL reset_ch got=%0d want=0", bus.out_ch); end
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_latency();
        bus.async_data[2] = 8'hA5;
        bus.async_req     = 4'b0100;
        tick(2);
        checks++; if (bus.out_valid !== 1'b0 || bus.ack !== 4'b0000) begin errors++; $display("FAIL lat_early valid=%b ack=%b want 0/0000", bus.out_valid, bus.ack); end
        tick(1);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL lat_valid got=%b want=1", bus.out_valid); end
        checks++; if (bus.out_data !== 8'hA5) begin errors++; $display("FAIL lat_data got=%h want=a5", bus.out_data); end
        checks++; if (bus.out_ch !== 2'd2) begin errors++; $display("FAIL lat_ch got=%0d want=2", bus.out_ch); end
        checks++; if (bus.ack !== 4'b0100) begin errors++; $display("FAIL lat_ack got=%b want=0100", bus.ack); end
        tick(1);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lat_accept got=%b want=0", bus.out_valid); end
        bus.async_req = 4'b0000;
        tick(2);
        checks++; if (bus.ack !== 4'b0100) begin errors++; $display("FAIL lat_ack_hold got=%b want=0100", bus.ack); end
        tick(1);
        checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL lat_ack_drop got=%b want=0000", bus.ack); end
    endtask

    // Last grant is ch2 on entry.
    task automatic test_round_robin();
        bus.async_data[1] = 8'h11;
        bus.async_data[3] = 8'h33;
        bus.async_req     = 4'b1010;
        tick(3);
        checks++; if (bus.out_ch !== 2'd3 || bus.out_data !== 8'h33) begin errors++; $display("FAIL rr_first ch=%0d data=%h want 3/33", bus.out_ch, bus.out_data); end
        checks++; if (bus.ack !== 4'b1000) begin errors++; $display("FAIL rr_first_ack got=%b want=1000", bus.ack); end
        tick(1);
        checks++; if (bus.out_ch !== 2'd1 || bus.out_data !== 8'h11 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL rr_second ch=%0d data=%h v=%b want 1/11/1", bus.out_ch, bus.out_data, bus.out_valid); end
        checks++; if (bus.ack !== 4'b1010) begin errors++; $display("FAIL rr_second_ack got=%b want=1010", bus.ack); end
        bus.async_req = 4'b0000;
        tick(4);
        checks++; if (bus.ack !== 4'b0000 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rr_idle ack=%b v=%b want 0000/0", bus.ack, bus.out_valid); end
    endtask

    task automatic test_all_four();
        logic [3:0] exp_ack;
        do_reset();
        for (int c = 0; c < 4; c++) bus.async_data[c] = 8'hC0 + 8'(c);
        bus.async_req = 4'b1111;
        tick(2);
        exp_ack = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            tick(1);
            exp_ack[c] = 1'b1;
            checks++; if (bus.out_ch !== 2'(c) || bus.out_data !== (8'hC0 + 8'(c)) || bus.out_valid !== 1'b1) begin errors++; $display("FAIL all4_word%0d ch=%0d data=%h v=%b", c, bus.out_ch, bus.out_data, bus.out_valid); end
            checks++; if (bus.ack !== exp_ack) begin errors++; $display("FAIL all4_ack%0d got=%b want=%b", c, bus.ack, exp_ack); end
        end
        bus.async_req = 4'b0000;
        tick(4);
        checks++; if (bus.ack !== 4'b0000) begin errors++; $display("FAIL all4_drop got=%b want=0000", bus.ack); end
    endtask

    // Last grant is ch3 on entry.
    task automatic test_back_to_back();
        bus.out_ready     = 1'b0;
        bus.async_data[1] = 8'h5A;
        bus.async_req     = 4'b0010;
        tick(3);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd1 || bus.out_data !== 8'h5A) begin errors++; $display("FAIL bp_load v=%b ch=%0d data=%h want 1/1/5a", bus.out_valid, bus.out_ch, bus.out_data); end
        bus.async_data[3] = 8'h3C;
        bus.async_req     = 4'b1010;
        tick(4);
        checks++; if (bus.ack[3] !== 1'b0) begin errors++; $display("FAIL bp_ack3 got=%b want=0", bus.ack[3]); end
        checks++; if (bus.out_data !== 8'h5A || bus.out_ch !== 2'd1 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold data=%h ch=%0d v=%b want 5a/1/1", bus.out_data, bus.out_ch, bus.out_valid); end
        bus.out_ready = 1'b1;
        tick(1);
        checks++; if (bus.out_data !== 8'h3C || bus.out_ch !== 2'd3 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_reload data=%h ch=%0d v=%b want 3c/3/1", bus.out_data, bus.out_ch, bus.out_valid); end
        checks++; if (bus.ack !== 4'b1010) begin errors++; $display("FAIL bp_reload_ack got=%b want=1010", bus.ack); end
        bus.async_req = 4'b0000;
        tick(4);
        checks++; if (bus.ack !== 4'b0000 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_idle ack=%b v=%b want 0000/0", bus.ack, bus.out_valid); end
    endtask

    task automatic test_held_req();
        int words;
        words = 0;
        bus.async_data[0] = 8'h77;
        bus.async_req     = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.out_valid === 1'b1) words++;
        end
        checks++; if (words !== 1) begin errors++; $display("FAIL held_words got=%0d want=1", words); end
        checks++; if (bus.ack !== 4'b0001) begin errors++; $display("FAIL held_ack got=%b want=0001", bus.ack); end
    endtask

    // Entered with req[0] still high and data 0x77.
    task automatic test_reset_mid();
        do_reset();
        bus.async_req = 4'b0001;
        bus.out_ready = 1'b0;
        tick(3);
        checks++; if (bus.ack !== 4'b0001 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre ack=%b v=%b want 0001/1", bus.ack, bus.out_valid); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.ack !== 4'b0000 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_async ack=%b v=%b want 0000/0", bus.ack, bus.out_valid); end
        checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL rmid_data got=%h want=00", bus.out_data); end
        tick(1);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        tick(2);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_early got=%b want=0", bus.out_valid); end
        tick(1);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h77 || bus.out_ch !== 2'd0) begin errors++; $display("FAIL rmid_redeliver v=%b data=%h ch=%0d want 1/77/0", bus.out_valid, bus.out_data, bus.out_ch); end
        bus.async_req = 4'b0000;
        tick(4);
    endtask

    // Scenario sequence.
    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_latency();
        test_round_robin();
        test_all_four();
        test_back_to_back();
        test_held_req();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_multi_ch_ack_sink
